// File: rtl/nv_ram_rws_512x128_fifo_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nv_ram_rws_512x128_fifo_ctrl_pkg                           |
// | Brief   : Shared widths and types for the 512x128 RAM FIFO controller|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package nv_ram_rws_512x128_fifo_ctrl_pkg;
    localparam int DW        = 128;
    localparam int AW        = 9;
    localparam int RAM_DEPTH = 512;
    localparam int CW        = AW + 1;

    typedef logic [DW-1:0] data_t;
    typedef logic [AW-1:0] addr_t;
    typedef logic [CW-1:0] cnt_t;
endpackage
`default_nettype wire

// File: rtl/nv_ram_rws_512x128.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nv_ram_rws_512x128                                         |
// | Brief   : 512x128 RAM model, registered read address, 1R1W          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nv_ram_rws_512x128 (
    input  logic         clk,
    input  logic [8:0]   ra,
    input  logic         re,
    output logic [127:0] dout,
    input  logic [8:0]   wa,
    input  logic         we,
    input  logic [127:0] di,
    input  logic [31:0]  pwrbus_ram_pd
);
    logic [127:0] mem_q [0:511];
    logic [8:0]   ra_q;
    logic         w_unused_pd;

    // dout follows the registered address, so a write landing on that
    // address at the capture edge is only visible in the following cycle.
    always_ff @(posedge clk) begin
        if (re) ra_q <= ra;
        if (we) mem_q[wa] <= di;
    end

    assign dout        = mem_q[ra_q];
    assign w_unused_pd = ^pwrbus_ram_pd;
endmodule
`default_nettype wire

// File: rtl/nv_ram_rws_512x128_fifo_ctrl_obuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nv_ram_fifo_obuf_2x128                                     |
// | Brief   : 2-entry output buffer with same-cycle capture and pop      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nv_ram_fifo_obuf_2x128
    import nv_ram_rws_512x128_fifo_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       cap_i,
    input  data_t      cap_data_i,
    input  logic       pop_i,
    output logic       vld_o,
    output data_t      data_o,
    output logic [1:0] cnt_o
);
    data_t      ent_q [2];
    logic       head_q;
    logic       tail_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            head_q <= 1'b0;
            tail_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (cap_i) tail_q <= ~tail_q;
            if (pop_i) head_q <= ~head_q;
            cnt_q <= cnt_q + {1'b0, cap_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (cap_i) ent_q[tail_q] <= cap_data_i;
    end

    assign vld_o  = (cnt_q != 2'd0);
    assign data_o = vld_o ? ent_q[head_q] : '0;
    assign cnt_o  = cnt_q;
endmodule
`default_nettype wire

// File: rtl/nv_ram_rws_512x128_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : nv_ram_rws_512x128_fifo_ctrl                               |
// | Brief   : Valid/ready FIFO over one 512x128 RAM plus 2-entry buffer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nv_ram_rws_512x128_fifo_ctrl
    import nv_ram_rws_512x128_fifo_ctrl_pkg::*;
#(
    parameter int AFULL_THRESH = 496
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          wr_afull,
    output logic [CW-1:0] wr_count,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    input  logic [31:0]   pwrbus_ram_pd
);
    addr_t      wp_q, wp_d;
    addr_t      rp_q, rp_d;
    cnt_t       ram_cnt_q, ram_cnt_d;
    logic       inflight_q;
    logic       prdy_q;
    logic       afull_q;
    logic       push, pop, issue;
    logic [1:0] ob_cnt;
    logic [2:0] ob_pending;
    data_t      ram_dout;

    assign push       = wr_pvld & prdy_q;
    assign pop        = rd_pvld & rd_prdy;
    // Slots the buffer will hold after this edge, counting the read in flight.
    assign ob_pending = {1'b0, ob_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue      = (ram_cnt_q != '0) && (ob_pending < 3'd2);

    always_comb begin
        wp_d      = push  ? wp_q + addr_t'(1) : wp_q;
        rp_d      = issue ? rp_q + addr_t'(1) : rp_q;
        ram_cnt_d = ram_cnt_q + cnt_t'(push) - cnt_t'(issue);
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            wp_q       <= '0;
            rp_q       <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            prdy_q     <= 1'b0;
            afull_q    <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= issue;
            prdy_q     <= (ram_cnt_d < cnt_t'(RAM_DEPTH));
            afull_q    <= (ram_cnt_q >= cnt_t'(AFULL_THRESH));
        end
    end

    nv_ram_rws_512x128 u_ram (
        .clk           (nvdla_core_clk),
        .ra            (rp_q),
        .re            (issue),
        .dout          (ram_dout),
        .wa            (wp_q),
        .we            (push),
        .di            (wr_pd),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    nv_ram_fifo_obuf_2x128 u_obuf (
        .clk_i      (nvdla_core_clk),
        .rstn_i     (nvdla_core_rstn),
        .cap_i      (inflight_q),
        .cap_data_i (ram_dout),
        .pop_i      (pop),
        .vld_o      (rd_pvld),
        .data_o     (rd_pd),
        .cnt_o      (ob_cnt)
    );

    assign wr_prdy  = prdy_q;
    assign wr_afull = afull_q;
    assign wr_count = ram_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_nv_ram_rws_512x128_fifo_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_nv_ram_rws_512x128_fifo_ctrl                            |
// | Brief   : Self-checking bench with queue model for the RAM FIFO      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_nv_ram_rws_512x128_fifo_ctrl;
    logic         clk = 1'b0;
    logic         rstn;
    logic         wr_pvld;
    logic         wr_prdy;
    logic [127:0] wr_pd;
    logic         wr_afull;
    logic [9:0]   wr_count;
    logic         rd_pvld;
    logic         rd_prdy;
    logic [127:0] rd_pd;

    int checks   = 0;
    int failures = 0;
    logic [127:0] q[$];
    int  pops       = 0;
    int  stall      = 0;
    int  prev_count = 0;
    bit  started    = 0;
    bit  rst_prev   = 0;

    always #5 clk = ~clk;

    nv_ram_rws_512x128_fifo_ctrl #(.AFULL_THRESH(496)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wr_pvld         (wr_pvld),
        .wr_prdy         (wr_prdy),
        .wr_pd           (wr_pd),
        .wr_afull        (wr_afull),
        .wr_count        (wr_count),
        .rd_pvld         (rd_pvld),
        .rd_prdy         (rd_prdy),
        .rd_pd           (rd_pd),
        .pwrbus_ram_pd   (32'd0)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the FIFO is an ordered queue of accepted words; the RAM count is
    // bounded by total occupancy minus at most two buffered/in-flight words.
    always @(negedge clk) begin
        if (rst_prev) begin
            chk("rst_wr_prdy", wr_prdy, 0);
            chk("rst_rd_pvld", rd_pvld, 0);
            chk("rst_wr_count", wr_count, 0);
            chk("rst_wr_afull", wr_afull, 0);
            started = 1;
        end else if (started) begin
            chk("prdy_vs_count", wr_prdy, wr_count != 10'd512);
            chk("count_le_occ", int'(wr_count) <= q.size(), 1);
            chk("occ_minus_count_le2", (q.size() - int'(wr_count)) <= 2, 1);
            chk("afull", wr_afull, prev_count >= 496);
            if (q.size() == 0) chk("empty_no_pvld", rd_pvld, 0);
            else if (rd_pvld) chk("head_data", rd_pd, q[0]);
            else begin
                stall++;
                chk("head_latency_le2", stall <= 2, 1);
            end
            if (rd_pvld || q.size() == 0) stall = 0;
        end
        if (!rstn) begin
            q.delete();
            prev_count = 0;
            stall      = 0;
        end else if (started) begin
            if (rd_pvld && rd_prdy && q.size() > 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (wr_pvld && wr_prdy) q.push_back(wr_pd);
            prev_count = int'(wr_count);
        end
        rst_prev = !rstn;
    end

    task automatic drain_all();
        int n;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 700) begin
            step();
            n++;
        end
        chk("drain_done", q.size() == 0, 1);
        step();
        chk("drain_count0", wr_count, 0);
        chk("drain_pvld0", rd_pvld, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c496, cafl, k, base, start_pops;
        logic [127:0] exp_v;
        rstn = 1'b0; wr_pvld = 1'b0; rd_prdy = 1'b0; wr_pd = '0;
        repeat (3) step();
        rstn = 1'b1;
        step();
        chk("post_rst_prdy", wr_prdy, 1);
        chk("post_rst_count", wr_count, 0);
        chk("post_rst_pvld", rd_pvld, 0);

        // Single push: visible three cycles after the handshake cycle.
        wr_pvld = 1'b1; wr_pd = {16{8'hA5}}; rd_prdy = 1'b1;
        step(); wr_pvld = 1'b0;
        chk("lat_c1_pvld", rd_pvld, 0); chk("lat_c1_count", wr_count, 1);
        step();
        chk("lat_c2_pvld", rd_pvld, 0); chk("lat_c2_count", wr_count, 0);
        step();
        chk("lat_c3_pvld", rd_pvld, 1); chk("lat_c3_data", rd_pd, {16{8'hA5}});
        step();
        chk("lat_c4_pvld", rd_pvld, 0); chk("lat_c4_count", wr_count, 0);

        // Fill with reader stalled.
        rd_prdy = 1'b0; n = 0; c496 = -1; cafl = -1;
        for (int cyc = 0; cyc < 620; cyc++) begin
            if (wr_count == 10'd496 && c496 < 0) c496 = cyc;
            if (wr_afull && cafl < 0) cafl = cyc;
            if (n < 514) begin
                wr_pvld = 1'b1; wr_pd = 128'(n);
                if (wr_prdy) n++;
            end else begin
                wr_pvld = 1'b1; wr_pd = 128'hDEAD;
                chk("full_prdy_low", wr_prdy, 0);
            end
            step();
            if (n == 514 && cyc > 530) break;
        end
        chk("fill_accepted", n, 514);
        chk("fill_count", wr_count, 512);
        chk("fill_prdy", wr_prdy, 0);
        chk("afull_delay", (c496 >= 0) && (cafl == c496 + 1), 1);

        // One pop at full, then a push the moment a slot is offered.
        wr_pvld = 1'b0; rd_prdy = 1'b1;
        step();
        rd_prdy = 1'b0;
        chk("pop_reopens_prdy", wr_prdy, 1);
        wr_pvld = 1'b1; wr_pd = 128'd1000;
        step();
        wr_pvld = 1'b0;
        chk("refull_prdy", wr_prdy, 0);
        chk("refull_count", wr_count, 512);

        rd_prdy = 1'b1; k = 0;
        for (int cyc = 0; cyc < 700 && k < 514; cyc++) begin
            if (rd_pvld) begin
                exp_v = (k < 513) ? 128'(k + 1) : 128'd1000;
                chk("drain_order", rd_pd, exp_v);
                k++;
            end
            step();
        end
        chk("drain_total", k, 514);
        chk("drain_empty_count", wr_count, 0);

        // Continuous streaming through the pointer wrap.
        wr_pvld = 1'b1; rd_prdy = 1'b1; base = 0;
        for (int i = 0; i < 2000; i++) begin
            wr_pd = 128'(5000 + i);
            if (i == 20) base = int'(wr_count);
            if (i >= 20) begin
                chk("stream_pvld", rd_pvld, 1);
                chk("stream_prdy", wr_prdy, 1);
                chk("stream_count", wr_count, base);
            end
            step();
        end
        drain_all();

        // Random handshakes.
        start_pops = pops;
        for (int cyc = 0; cyc < 40000 && (pops - start_pops) < 10000; cyc++) begin
            wr_pvld = 1'($urandom_range(0, 1));
            rd_prdy = 1'($urandom_range(0, 1));
            wr_pd   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        chk("random_beats", (pops - start_pops) >= 10000, 1);
        drain_all();

        // Reset while 300 entries are queued and a read is in flight.
        rd_prdy = 1'b0; n = 0;
        for (int cyc = 0; cyc < 400 && n < 300; cyc++) begin
            wr_pvld = 1'b1; wr_pd = 128'(7000 + n);
            if (wr_prdy) n++;
            step();
        end
        wr_pvld = 1'b0;
        chk("pre_rst_queued", n, 300);
        step(); step();
        rd_prdy = 1'b1;
        step();
        rd_prdy = 1'b0; rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("midrst_pvld", rd_pvld, 0);
        chk("midrst_count", wr_count, 0);
        step();
        chk("midrst_prdy", wr_prdy, 1);
        wr_pvld = 1'b1; wr_pd = 128'h1234; rd_prdy = 1'b1;
        step();
        wr_pvld = 1'b0;
        k = 0;
        while (!rd_pvld && k < 10) begin
            step();
            k++;
        end
        chk("midrst_first_seen", rd_pvld, 1);
        chk("midrst_first_data", rd_pd, 128'h1234);
        drain_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
